// File: rtl/qla_pkg.sv
// Shared definitions for the Q-learning update engine: FSM state encoding,
// shift-field decode constants and saturation limits.
package qla_pkg;

   // Engine sequencing states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CALC = 3'd2,
      WR   = 3'd3,
      CLR  = 3'd4
   } state_e;

   // Each alpha/gamma word carries three shift fields [i|j|k]; field value 0 disables that term
   localparam int NUM_FIELDS = 3;
   localparam int FIELD_OFF  = 0;

   // Guard bits added above DW so every intermediate of the update stays exact
   localparam int EXT_BITS = 3;

   // Largest representable DW-bit signed value
   function automatic longint sat_hi(input int dw);
      return (longint'(1) <<< (dw - 1)) - 1;
   endfunction

   // Smallest representable DW-bit signed value
   function automatic longint sat_lo(input int dw);
      return -(longint'(1) <<< (dw - 1));
   endfunction

endpackage

// File: rtl/qla_shift_mult.sv
// Shift-and-add multiply by a coefficient built from three shift fields:
// coefficient = sum of 2^-f over the nonzero fields f. Each term is an
// arithmetic right shift, so every term floors independently.
module qla_shift_mult
   import qla_pkg::*;
#(
   parameter int W   = 19,
   parameter int SHW = 4
) (
   input  logic [NUM_FIELDS*SHW-1:0] fields,
   input  logic signed [W-1:0]       opnd,
   output logic signed [W-1:0]       prod
);

   // Accumulate one shifted copy of the operand per enabled field
   always_comb begin
      prod = '0;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         if (fields[f*SHW +: SHW] != SHW'(FIELD_OFF))
            prod = prod + (opnd >>> fields[f*SHW +: SHW]);
      end
   end

endmodule

// File: rtl/qla_update_engine.sv
// Q-learning table update engine. One update per request:
//   Q(st,act) <= Q + alfa*(rt + gamma*max(Q(nxtst,*)) - Q)
// sequenced IDLE -> RD -> CALC -> WR, plus a row-per-cycle table clear.
// Build option: define QLA_SATURATE_EN to clip the result to the DW-bit
// signed range and report clipping on sat_flag; otherwise the result wraps.
module qla_update_engine
   import qla_pkg::*;
#(
   parameter int DW          = 16,
   parameter int FRAC        = 8,
   parameter int NUM_STATES  = 256,
   parameter int NUM_ACTIONS = 4,
   parameter int SHW         = 4,
   localparam int SW = $clog2(NUM_STATES),
   localparam int AW = $clog2(NUM_ACTIONS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [SW-1:0]             st,
   input  logic [SW-1:0]             nxtst,
   input  logic [AW-1:0]             act,
   input  logic [DW-1:0]             rt,
   input  logic                      terminal,
   input  logic [3*SHW-1:0]          alfa,
   input  logic [3*SHW-1:0]          gamma,
   output logic                      done,
   output logic [DW-1:0]             qnew,
   output logic                      sat_flag,
   input  logic                      clr,
   output logic                      busy,
   input  logic [SW-1:0]             pol_st,
   output logic [NUM_ACTIONS*DW-1:0] qrow
);

   localparam int EW = DW + EXT_BITS;

   if (FRAC >= DW) begin : g_frac_chk
      $error("FRAC must be smaller than DW");
   end
   if (NUM_ACTIONS < 2) begin : g_act_chk
      $error("NUM_ACTIONS must be at least 2");
   end

   state_e state;

   // Captured request
   logic [SW-1:0]           st_r, nxtst_r, clr_idx;
   logic [AW-1:0]           act_r;
   logic signed [DW-1:0]    rt_r;
   logic                    term_r;
   logic [3*SHW-1:0]        alfa_r, gamma_r;

   // Values fetched in RD
   logic signed [DW-1:0]    q_sa_r, m_r;
   logic                    sa_ok_r;

   // Q table, one packed row per state; contents survive reset
   logic [NUM_ACTIONS-1:0][DW-1:0] mem [NUM_STATES];

   logic [NUM_ACTIONS-1:0][DW-1:0] row_st, row_nxt;
   logic signed [DW-1:0]    row_max;
   logic                    st_ok, nxt_ok, act_ok, pol_ok;

   logic signed [EW-1:0]    q_x, m_x, rt_x, gm, delta, ad, sum;
   logic [DW-1:0]           res;
   logic                    res_sat;

   assign req_ready = (state == IDLE) & ~clr;

   // Widened compares keep the range checks meaningful for non-power-of-two sizes
   assign st_ok  = ({1'b0, st_r}    < (SW+1)'(NUM_STATES));
   assign nxt_ok = ({1'b0, nxtst_r} < (SW+1)'(NUM_STATES));
   assign pol_ok = ({1'b0, pol_st}  < (SW+1)'(NUM_STATES));
   assign act_ok = ({1'b0, act_r}   < (AW+1)'(NUM_ACTIONS));

   assign row_st  = st_ok  ? mem[st_r]    : '0;
   assign row_nxt = nxt_ok ? mem[nxtst_r] : '0;

   // Signed maximum over the next-state row
   always_comb begin
      row_max = signed'(row_nxt[0]);
      for (int a = 1; a < NUM_ACTIONS; a++) begin
         if (signed'(row_nxt[a]) > row_max) row_max = signed'(row_nxt[a]);
      end
   end

   assign q_x  = EW'(q_sa_r);
   assign m_x  = EW'(m_r);
   assign rt_x = EW'(rt_r);

   qla_shift_mult #(.W(EW), .SHW(SHW)) u_gamma (
      .fields (gamma_r),
      .opnd   (m_x),
      .prod   (gm)
   );

   // Terminal states drop the discounted future term
   assign delta = term_r ? (rt_x - q_x) : (rt_x + gm - q_x);

   qla_shift_mult #(.W(EW), .SHW(SHW)) u_alfa (
      .fields (alfa_r),
      .opnd   (delta),
      .prod   (ad)
   );

   assign sum = q_x + ad;

`ifdef QLA_SATURATE_EN
   localparam logic signed [EW-1:0] SAT_HI = EW'(sat_hi(DW));
   localparam logic signed [EW-1:0] SAT_LO = EW'(sat_lo(DW));

   // Clip the exact result into the DW-bit signed range
   always_comb begin
      res     = DW'(sum);
      res_sat = 1'b0;
      if (sum > SAT_HI) begin
         res     = DW'(SAT_HI);
         res_sat = 1'b1;
      end else if (sum < SAT_LO) begin
         res     = DW'(SAT_LO);
         res_sat = 1'b1;
      end
   end
`else
   assign res     = DW'(sum);
   assign res_sat = 1'b0;
`endif

   // Sequencer with registered handshake/result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         done     <= 1'b0;
         qnew     <= '0;
         sat_flag <= 1'b0;
         busy     <= 1'b0;
         clr_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (clr) begin
                  state   <= CLR;
                  busy    <= 1'b1;
                  clr_idx <= '0;
               end else if (req_valid) begin
                  state <= RD;
                  busy  <= 1'b1;
               end
            end
            RD:   state <= CALC;
            CALC: begin
               qnew     <= sa_ok_r ? res : '0;
               sat_flag <= sa_ok_r & res_sat;
               done     <= 1'b1;
               state    <= WR;
            end
            WR: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            CLR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == SW'(NUM_STATES - 1)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Request capture on accept and operand fetch during RD
   always_ff @(posedge clk) begin
      if (state == IDLE && req_ready && req_valid) begin
         st_r    <= st;
         nxtst_r <= nxtst;
         act_r   <= act;
         rt_r    <= rt;
         term_r  <= terminal;
         alfa_r  <= alfa;
         gamma_r <= gamma;
      end
      if (state == RD) begin
         q_sa_r  <= (st_ok && act_ok) ? signed'(row_st[act_r]) : '0;
         m_r     <= nxt_ok ? row_max : '0;
         sa_ok_r <= st_ok & act_ok;
      end
   end

   // Table writes: update commit at the end of WR, one zero row per CLR cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == WR && sa_ok_r) mem[st_r][act_r] <= qnew;
         if (state == CLR)           mem[clr_idx]     <= '0;
      end
   end

   // Policy read port; a same-edge write shows up one cycle later
   always_ff @(posedge clk) begin
      if (rst) qrow <= '0;
      else     qrow <= pol_ok ? mem[pol_st] : '0;
   end

endmodule

// File: tb/tb_qla_update_engine.sv
// Self-checking bench for qla_update_engine: vector table through a
// scoreboard, plus clear, same-row write/read and mid-operation reset sequences.
module tb_qla_update_engine;

   localparam int DW = 16, FRAC = 8, NS = 256, NA = 4, SHW = 4;
   localparam int SW = 8, AW = 2;

   logic              clk = 1'b0, rst = 1'b1;
   logic              req_valid = 1'b0, req_ready;
   logic [SW-1:0]     st = '0, nxtst = '0, pol_st = '0;
   logic [AW-1:0]     act = '0;
   logic [DW-1:0]     rt = '0;
   logic              terminal = 1'b0, clr = 1'b0;
   logic [3*SHW-1:0]  alfa = '0, gamma = '0;
   logic              done, sat_flag, busy;
   logic [DW-1:0]     qnew;
   logic [NA*DW-1:0]  qrow;

   qla_update_engine #(.DW(DW), .FRAC(FRAC), .NUM_STATES(NS), .NUM_ACTIONS(NA), .SHW(SHW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .st(st), .nxtst(nxtst), .act(act), .rt(rt), .terminal(terminal),
      .alfa(alfa), .gamma(gamma), .done(done), .qnew(qnew), .sat_flag(sat_flag),
      .clr(clr), .busy(busy), .pol_st(pol_st), .qrow(qrow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  st, nxtst;
      logic [1:0]  act;
      logic [15:0] rt;
      logic        term;
      logic [11:0] alfa, gamma;
      logic [15:0] eq;
      logic        es;
   } vec_t;

   typedef struct {
      logic [15:0] q;
      logic        s;
      int          due;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int nvec = 0, nerr = 0;

`ifdef QLA_SATURATE_EN
   localparam logic [15:0] BIG_Q = 16'h7FFF;
   localparam logic        BIG_S = 1'b1;
   localparam logic [15:0] NEG_Q = 16'h1FFF;
`else
   localparam logic [15:0] BIG_Q = 16'hA800;
   localparam logic        BIG_S = 1'b0;
   localparam logic [15:0] NEG_Q = 16'h0000;
`endif

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sbq.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk("qnew", {48'h0, qnew}, {48'h0, mon_e.q});
            chk("sat_flag", {63'h0, sat_flag}, {63'h0, mon_e.s});
            chk("latency", 64'(cyc), 64'(mon_e.due));
         end
      end
   end

   task automatic issue(input vec_t v, input bit push);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         nvec++;
         nerr++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
         return;
      end
      st = v.st; nxtst = v.nxtst; act = v.act; rt = v.rt;
      terminal = v.term; alfa = v.alfa; gamma = v.gamma;
      req_valid = 1'b1;
      if (push) sbq.push_back('{v.eq, v.es, cyc + 3});
      @(posedge clk);
      #1;
      // Scramble inputs after accept: the engine must use the captured copy
      req_valid = 1'b0;
      st = 8'($urandom); nxtst = 8'($urandom); act = 2'($urandom);
      rt = 16'($urandom); terminal = 1'($urandom);
      alfa = 12'($urandom); gamma = 12'($urandom);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sbq.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         nvec++;
         nerr++;
         sbq.delete();
         $display("FAIL done_timeout: got no done expected done (cycle %0d)", cyc);
      end
   endtask

   task automatic rowchk(input string nm, input logic [7:0] s, input logic [63:0] exp);
      @(negedge clk);
      pol_st = s;
      @(negedge clk);
      chk(nm, qrow, exp);
   endtask

   vec_t vt[7];

   initial begin
      int busy_cnt, rdy_bad, bad, n, dcnt;

      vt[0] = '{8'd3, 8'd4, 2'd1, 16'h0100, 1'b0, 12'h100, 12'h120, 16'h0080, 1'b0};
      vt[1] = '{8'd2, 8'd3, 2'd0, 16'h0000, 1'b0, 12'h100, 12'h120, 16'h0030, 1'b0};
      vt[2] = '{8'd3, 8'd9, 2'd1, 16'h0100, 1'b1, 12'h100, 12'h120, 16'h00C0, 1'b0};
      vt[3] = '{8'd5, 8'd6, 2'd0, 16'h7000, 1'b0, 12'h111, 12'h000, BIG_Q,    BIG_S};
      vt[4] = '{8'd7, 8'd3, 2'd2, 16'hFEFF, 1'b0, 12'h001, 12'h100, 16'hFFAF, 1'b0};
      vt[5] = '{8'd3, 8'd3, 2'd0, 16'h0000, 1'b0, 12'h100, 12'h100, 16'h0030, 1'b0};
      vt[6] = '{8'd8, 8'd5, 2'd3, 16'h0000, 1'b0, 12'h100, 12'h100, NEG_Q,    1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_qnew", {48'h0, qnew}, 64'h0);
      chk("rst_sat", {63'h0, sat_flag}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_qrow", qrow, 64'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {63'h0, req_ready}, 64'h1);

      // Clear wins over a simultaneous request
      clr = 1'b1; req_valid = 1'b1; st = 8'd1; act = 2'd1; rt = 16'h0100; alfa = 12'h100;
      #1;
      chk("ready_during_clr", {63'h0, req_ready}, 64'h0);
      @(posedge clk);
      #1;
      clr = 1'b0; req_valid = 1'b0;
      busy_cnt = 0; rdy_bad = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) break;
         busy_cnt++;
         if (req_ready) rdy_bad++;
      end
      chk("clr_busy_cycles", 64'(busy_cnt), 64'd256);
      chk("clr_ready_low", 64'(rdy_bad), 64'd0);
      chk("ready_after_clr", {63'h0, req_ready}, 64'h1);
      bad = 0;
      for (int s = 0; s < NS; s++) begin
         pol_st = 8'(s);
         @(negedge clk);
         if (qrow !== 64'h0) bad++;
      end
      chk("clr_rows_zero", 64'(bad), 64'd0);

      // Vector table through the scoreboard
      for (int i = 0; i < 7; i++) begin
         issue(vt[i], 1'b1);
         wait_drain();
      end

      rowchk("qrow_row2", 8'd2, 64'h0000_0000_0000_0030);
      rowchk("qrow_row3", 8'd3, 64'h0000_0000_00C0_0030);
      rowchk("qrow_row5", 8'd5, {48'h0, BIG_Q});
      rowchk("qrow_row7", 8'd7, 64'h0000_FFAF_0000_0000);

      // Policy read of a row being written returns the old value first
      pol_st = 8'd2;
      issue('{8'd2, 8'd0, 2'd1, 16'h0100, 1'b1, 12'h100, 12'h000, 16'h0080, 1'b0}, 1'b1);
      n = 0;
      while (!done && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("qrow_old_on_write", {48'h0, qrow[31:16]}, 64'h0);
      @(negedge clk);
      chk("qrow_new_after_write", {48'h0, qrow[31:16]}, 64'h0080);
      wait_drain();

      // Reset during CALC aborts the update
      issue('{8'd7, 8'd0, 2'd2, 16'h0100, 1'b1, 12'h100, 12'h000, 16'h0000, 1'b0}, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_abort", {63'h0, req_ready}, 64'h1);
      dcnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) dcnt++;
         @(negedge clk);
      end
      chk("no_done_after_abort", 64'(dcnt), 64'd0);
      rowchk("row7_unchanged", 8'd7, 64'h0000_FFAF_0000_0000);

      // Request accepted normally after the abort
      issue('{8'd9, 8'd2, 2'd0, 16'h0000, 1'b0, 12'h100, 12'h100, 16'h0020, 1'b0}, 1'b1);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
